// File: rtl/dccm_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dccm_arb_if : LSU / DMA requester, DCCM and finish signals of dccm_arb  |
// | Revision    : 1.0                                                       |
// +--------------------------------------------------------------------------+
interface dccm_arb_if #(
   parameter int XLEN = 32
) ();
   logic            lsu_req;
   logic            lsu_we;
   logic [XLEN-1:0] lsu_addr;
   logic [XLEN-1:0] lsu_wdata;
   logic [3:0]      lsu_wstrb;
   logic            lsu_gnt;
   logic            lsu_rvalid;
   logic [XLEN-1:0] lsu_rdata;

   logic            dma_req;
   logic            dma_we;
   logic [XLEN-1:0] dma_addr;
   logic [XLEN-1:0] dma_wdata;
   logic [3:0]      dma_wstrb;
   logic            dma_gnt;
   logic            dma_rvalid;
   logic [XLEN-1:0] dma_rdata;

   logic            dccm_en;
   logic            dccm_wen;
   logic [XLEN-1:0] dccm_addr;
   logic [XLEN-1:0] dccm_wdata;
   logic [3:0]      dccm_wstrb;
   logic [XLEN-1:0] dccm_rdata;

   logic            finish;

   // Arbiter side
   modport slave (
      input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb,
      output dma_gnt, dma_rvalid, dma_rdata,
      output dccm_en, dccm_wen, dccm_addr, dccm_wdata, dccm_wstrb,
      input  dccm_rdata,
      output finish
   );

   // Requester / memory side
   modport master (
      output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  dccm_en, dccm_wen, dccm_addr, dccm_wdata, dccm_wstrb,
      output dccm_rdata,
      input  finish
   );
endinterface
`default_nettype wire

// File: rtl/dccm_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dccm_arb : LSU/DMA arbiter for the DCCM with DMA anti-starvation and    |
// |            an MMIO finish-address trap. Revision : 1.0                  |
// +--------------------------------------------------------------------------+
module dccm_arb #(
   parameter int              XLEN         = 32,
   parameter int              STARVE_LIMIT = 8,
   parameter logic [XLEN-1:0] FINISH_ADDR  = XLEN'(32'h1000_0000)
) (
   input logic       clk,
   input logic       rst,
   dccm_arb_if.slave bus
);

   typedef enum logic [0:0] {
      ST_NORM  = 1'b0,
      ST_FORCE = 1'b1
   } state_e;

   localparam logic [8:0] c_limit = 9'(STARVE_LIMIT);

   state_e     state_q;
   logic [7:0] starve_cnt_q;
   logic [7:0] starve_cnt_d;
   logic       rd_pending_q;
   logic       rd_owner_q;   // 1 = DMA owns the outstanding read
   logic       finish_q;

   logic            w_lsu_gnt;
   logic            w_dma_gnt;
   logic            w_any_gnt;
   logic            w_win_we;
   logic [XLEN-1:0] w_win_addr;
   logic [XLEN-1:0] w_win_wdata;
   logic [3:0]      w_win_wstrb;
   logic            w_finish_hit;
   logic            w_dccm_en;
   logic [8:0]      w_starve_next;
   logic            w_dma_wait;
   logic            w_starve_hit;
   logic            w_lsu_rvalid;
   logic            w_dma_rvalid;

   always_comb begin
      w_lsu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
      if (!rst) begin
         if (state_q == ST_FORCE) begin
            w_dma_gnt = bus.dma_req;
            w_lsu_gnt = bus.lsu_req & ~bus.dma_req;
         end else begin
            w_lsu_gnt = bus.lsu_req;
            w_dma_gnt = bus.dma_req & ~bus.lsu_req;
         end
      end
   end

   assign w_any_gnt = w_lsu_gnt | w_dma_gnt;

   always_comb begin
      w_win_we    = 1'b0;
      w_win_addr  = '0;
      w_win_wdata = '0;
      w_win_wstrb = '0;
      if (w_dma_gnt) begin
         w_win_we    = bus.dma_we;
         w_win_addr  = bus.dma_addr;
         w_win_wdata = bus.dma_wdata;
         w_win_wstrb = bus.dma_wstrb;
      end else if (w_lsu_gnt) begin
         w_win_we    = bus.lsu_we;
         w_win_addr  = bus.lsu_addr;
         w_win_wdata = bus.lsu_wdata;
         w_win_wstrb = bus.lsu_wstrb;
      end
   end

   // A write to the finish address is acknowledged but never reaches the DCCM
   assign w_finish_hit = w_any_gnt & w_win_we & (w_win_addr == FINISH_ADDR);
   assign w_dccm_en    = w_any_gnt & ~w_finish_hit;

   assign bus.lsu_gnt    = w_lsu_gnt;
   assign bus.dma_gnt    = w_dma_gnt;
   assign bus.dccm_en    = w_dccm_en;
   assign bus.dccm_wen   = w_dccm_en & w_win_we;
   assign bus.dccm_addr  = w_win_addr;
   assign bus.dccm_wdata = w_win_wdata;
   assign bus.dccm_wstrb = w_win_wstrb;

   assign w_dma_wait    = bus.dma_req & ~w_dma_gnt;
   assign w_starve_next = {1'b0, starve_cnt_q} + 9'd1;
   assign w_starve_hit  = w_dma_wait & (w_starve_next == c_limit);
   assign starve_cnt_d  = w_dma_wait ? w_starve_next[7:0] : 8'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_NORM;
         starve_cnt_q <= 8'd0;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_pending_q <= w_any_gnt & ~w_win_we;
         rd_owner_q   <= w_dma_gnt;
         if (w_finish_hit) begin
            finish_q <= 1'b1;
         end
         case (state_q)
            ST_NORM: begin
               if (w_starve_hit) begin
                  state_q <= ST_FORCE;
               end
            end
            ST_FORCE: begin
               if (w_dma_gnt || !bus.dma_req) begin
                  state_q <= ST_NORM;
               end
            end
            default: state_q <= ST_NORM;
         endcase
      end
   end

   // Gating with rst drops a response whose read was granted just before reset
   assign w_lsu_rvalid   = rd_pending_q & ~rd_owner_q & ~rst;
   assign w_dma_rvalid   = rd_pending_q &  rd_owner_q & ~rst;
   assign bus.lsu_rvalid = w_lsu_rvalid;
   assign bus.dma_rvalid = w_dma_rvalid;
   assign bus.lsu_rdata  = w_lsu_rvalid ? bus.dccm_rdata : '0;
   assign bus.dma_rdata  = w_dma_rvalid ? bus.dccm_rdata : '0;
   assign bus.finish     = finish_q;

endmodule
`default_nettype wire

// File: doc/dccm_arb.md
DCCM_ARB -- requirements
Module: dccm_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the count of consecutive DMA wait cycles that forces a DMA grant (range 1..255).
REQ-003 The block SHALL have parameter FINISH_ADDR, default 32'h10000000, meaning the MMIO finish address.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning the reset; it is synchronous and active-high.
REQ-006 The block SHALL have ports lsu_req/lsu_we, input, 1 each, meaning LSU request and write-not-read.
REQ-007 The block SHALL have ports lsu_addr/lsu_wdata, input, XLEN each, meaning LSU address and write data.
REQ-008 The block SHALL have port lsu_wstrb, input, 4, meaning LSU byte enables.
REQ-009 The block SHALL have port lsu_gnt, output, 1, meaning the LSU request is accepted this cycle.
REQ-010 The block SHALL have ports lsu_rvalid, output, 1, and lsu_rdata, output, XLEN, meaning LSU read data valid and read data.
REQ-011 The block SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb, dma_gnt, dma_rvalid and dma_rdata, with the same widths and meanings as the lsu_* ports, for the DMA/loader requester.
REQ-012 The block SHALL have ports dccm_en and dccm_wen, output, 1 each, meaning DCCM access and write.
REQ-013 The block SHALL have ports dccm_addr/dccm_wdata, output, XLEN each, meaning DCCM address and write data.
REQ-014 The block SHALL have port dccm_wstrb, output, 4, meaning DCCM byte enables.
REQ-015 The block SHALL have port dccm_rdata, input, XLEN, meaning DCCM read data, valid 1 cycle after a read access.
REQ-016 The block SHALL have port finish, output, 1, meaning a sticky finish-sequence flag.

Function
REQ-017 The block SHALL grant at most one requester per cycle; lsu_gnt and dma_gnt SHALL be combinational and never both high.
REQ-018 The FSM SHALL have two states: NORM (LSU priority) and FORCE (DMA priority).
REQ-019 In NORM, lsu_req SHALL win; dma_gnt SHALL be high only when dma_req is high and lsu_req is low.
REQ-020 In FORCE, dma_req SHALL win; lsu_gnt SHALL be high only when lsu_req is high and dma_req is low.
REQ-021 starve_cnt (8 bit) SHALL increment each cycle dma_req is high with dma_gnt low, SHALL clear on dma_gnt, and SHALL clear when dma_req is low.
REQ-022 NORM SHALL transition to FORCE on the edge where starve_cnt+1 reaches STARVE_LIMIT.
REQ-023 FORCE SHALL return to NORM on the edge after any dma_gnt, and on any cycle dma_req is low.
REQ-024 On a grant, dccm_en SHALL be high that same cycle.
REQ-025 On a grant, dccm_addr, dccm_wdata and dccm_wstrb SHALL be driven from the winning requester that same cycle.
REQ-026 On a grant, dccm_wen SHALL equal the winner's we, except as stated in REQ-030.
REQ-027 With no grant, dccm_en and dccm_wen SHALL be 0; the other DCCM outputs are don't-care but SHALL hold 0.
REQ-028 A granted read SHALL set rd_pending/rd_owner for exactly one cycle; the next cycle, the owner's rvalid SHALL be 1 and its rdata SHALL equal dccm_rdata. The non-owner's rvalid SHALL be 0 and its rdata SHALL be 0.
REQ-029 Back-to-back reads SHALL be supported at one per cycle with no bubble; reads alternating between owners SHALL route each response to its own owner.
REQ-030 A granted write with address equal to FINISH_ADDR SHALL drive dccm_wen=0 and dccm_en=0, SHALL still assert the requester's gnt, and SHALL set finish on the next edge.
REQ-031 finish SHALL remain 1 until reset.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 A simultaneous dma_req and lsu_req while starve_cnt+1 equals STARVE_LIMIT SHALL grant the LSU in that cycle; the DMA SHALL win the following cycle.

Reset
REQ-034 While rst is high at a clock edge, the state SHALL become NORM.
REQ-035 While rst is high at a clock edge, starve_cnt, rd_pending, rd_owner and finish SHALL become 0.
REQ-036 During reset, outputs lsu_rvalid, dma_rvalid, lsu_rdata and dma_rdata SHALL read 0 from the cycle after the reset edge.
REQ-037 Grants SHALL be suppressed (0) while rst is high.
REQ-038 A read granted in the cycle before rst rises SHALL NOT produce rvalid.

Verification
REQ-039 The bench SHALL cover: LSU read of addr 0x40 with DCCM returning 0xDEADBEEF -> lsu_gnt in cycle 0; lsu_rvalid=1 and lsu_rdata=0xDEADBEEF in cycle 1; dma_rvalid=0.
REQ-040 The bench SHALL cover: lsu_req and dma_req held high continuously, STARVE_LIMIT=8 -> LSU granted for cycles 0-7; DMA granted in cycle 8; LSU granted from cycle 9.
REQ-041 The bench SHALL cover: DMA write 0x12345678, strb 0xF, to 0x10000000 -> dma_gnt=1 with dccm_en=0 and dccm_wen=0; finish=1 from the next cycle and still 1 after 100 cycles.
REQ-042 The bench SHALL cover: reads alternating LSU 0x0, DMA 0x4, LSU 0x8 on consecutive cycles -> rvalid sequence LSU, DMA, LSU, each carrying that cycle's dccm_rdata.
REQ-043 The bench SHALL cover: rst asserted in the cycle after an LSU read grant -> no lsu_rvalid, finish=0, and a dma_req in the first cycle after reset is granted with starve_cnt=0.
